// File: rtl/brr_encoder_if.sv
// brr_encoder_if: sample stream and RAM write port of the BRR encoder
interface brr_encoder_if;
  logic signed [15:0] sample_in;
  logic sample_valid;
  logic sample_ready;
  logic last_block;
  logic loop_flag;
  logic [15:0] ram_address;
  logic [7:0] ram_data_out;
  logic ram_write_request;
  logic ram_write_ack;
  modport master (
    output sample_in, sample_valid, last_block, loop_flag, ram_write_ack,
    input sample_ready, ram_address, ram_data_out, ram_write_request
  );
  modport slave (
    input sample_in, sample_valid, last_block, loop_flag, ram_write_ack,
    output sample_ready, ram_address, ram_data_out, ram_write_request
  );
endinterface

// File: rtl/brr_encoder.sv
// brr_encoder: packs 16-sample PCM blocks into 9-byte filter-0 BRR blocks written to RAM
module brr_encoder #(
  parameter int MAX_SHIFT = 12
) (
  input logic clock,
  input logic reset,
  input logic start,
  input logic [15:0] start_address,
  output logic busy,
  output logic done,
  brr_encoder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, COLLECT, SHIFT, WRITE_HEADER, WRITE_DATA} state_t;
  state_t state, state_n;
  logic signed [15:0] smp [16];
  logic signed [15:0] mn, mx, lo, hi;
  logic [15:0] ptr;
  logic [3:0] cnt, shift, shift_n;
  logic [2:0] idx;
  logic end_c, loop_c, take, ack, req, last_ack;
  logic [7:0] header, data_byte;
  function automatic logic [3:0] nibble(input logic signed [15:0] x, input logic [3:0] s);
    logic signed [15:0] v;
    v = x >>> s;
    return v > 16'sd7 ? 4'h7 : v < -16'sd8 ? 4'h8 : v[3:0];
  endfunction
  assign take = state == COLLECT && bus.sample_valid;
  assign req = state == WRITE_HEADER || state == WRITE_DATA;
  assign ack = req && bus.ram_write_ack;
  assign last_ack = state == WRITE_DATA && ack && idx == 3'd7;
  assign lo = cnt == 4'd0 || bus.sample_in < mn ? bus.sample_in : mn;
  assign hi = cnt == 4'd0 || bus.sample_in > mx ? bus.sample_in : mx;
  assign header = {shift, 2'b00, loop_c, end_c};
  assign data_byte = {nibble(smp[{idx, 1'b0}], shift), nibble(smp[{idx, 1'b1}], shift)};
  assign bus.sample_ready = state == COLLECT;
  assign bus.ram_write_request = req;
  assign bus.ram_address = req ? ptr : '0;
  assign bus.ram_data_out = state == WRITE_HEADER ? header : state == WRITE_DATA ? data_byte : '0;
  assign busy = state != IDLE;
  // smallest shift that fits both extremes into a signed nibble
  always_comb begin
    shift_n = 4'(MAX_SHIFT);
    for (int i = MAX_SHIFT; i >= 0; i--)
      if ((mx >>> i) <= 16'sd7 && (mn >>> i) >= -16'sd8) shift_n = 4'(i);
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? COLLECT : IDLE;
      COLLECT: state_n = take && cnt == 4'd15 ? SHIFT : COLLECT;
      SHIFT: state_n = WRITE_HEADER;
      WRITE_HEADER: state_n = ack ? WRITE_DATA : WRITE_HEADER;
      WRITE_DATA: state_n = last_ack ? (end_c ? IDLE : COLLECT) : WRITE_DATA;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) state <= reset ? IDLE : state_n;
  always_ff @(posedge clock) if (take) smp[cnt] <= bus.sample_in;
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
      mn <= '0;
      mx <= '0;
      idx <= '0;
      shift <= '0;
      end_c <= 1'b0;
      loop_c <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= last_ack && end_c;
      if (state == IDLE && start) ptr <= start_address;
      if (take) begin
        cnt <= cnt + 4'd1;
        mn <= lo;
        mx <= hi;
        if (cnt == 4'd15) begin
          end_c <= bus.last_block;
          loop_c <= bus.loop_flag & bus.last_block;
        end
      end
      if (state == SHIFT) begin
        shift <= shift_n;
        idx <= '0;
      end
      if (ack) begin
        ptr <= ptr + 16'd1;
        if (state == WRITE_DATA) idx <= idx + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_brr_encoder.sv
// tb_brr_encoder: table vectors, reset corner cases and randomized runs against an arithmetic BRR model
module tb_brr_encoder;
  localparam int MAX_SHIFT = 12;
  logic clock, reset, start, busy, done;
  logic [15:0] start_address;
  brr_encoder_if bus();
  brr_encoder #(.MAX_SHIFT(MAX_SHIFT)) dut (
    .clock(clock), .reset(reset), .start(start), .start_address(start_address),
    .busy(busy), .done(done), .bus(bus)
  );
  int tests = 0, fails = 0, ack_delay = 0, wcnt = 0, done_cnt = 0;
  logic held;
  logic [15:0] h_addr, exp_addr;
  logic [7:0] h_data;
  logic [15:0] blk [16];
  logic [23:0] wlog [$];
  logic [23:0] expq [$];
  typedef struct {
    logic [15:0] addr, s0, s1, ev, od;
    bit last, loop;
    logic [7:0] hdr, b0, bn;
  } vec_t;
  vec_t tv [10];
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  // RAM side: log accepted writes, check hold-while-waiting, and generate delayed acks
  always @(posedge clock) begin
    if (!reset && bus.ram_write_request && bus.ram_write_ack)
      wlog.push_back({bus.ram_address, bus.ram_data_out});
    #1;
    if (done) done_cnt++;
    if (reset) begin
      bus.ram_write_ack = 0;
      wcnt = 0;
      held = 0;
    end else begin
      if (held) begin
        check("hold_req", bus.ram_write_request, 1);
        check("hold_addr", bus.ram_address, h_addr);
        check("hold_data", bus.ram_data_out, h_data);
      end
      if (!bus.ram_write_request) begin
        bus.ram_write_ack = 0;
        wcnt = 0;
        held = 0;
      end else if (wcnt >= ack_delay) begin
        bus.ram_write_ack = 1;
        wcnt = 0;
        held = 0;
      end else begin
        bus.ram_write_ack = 0;
        wcnt++;
        held = 1;
        h_addr = bus.ram_address;
        h_data = bus.ram_data_out;
      end
    end
  end
  function automatic int fdiv(input int a, input int s);
    int d = 1 << s;
    int q = a / d;
    if (a < 0 && q * d != a) q--;
    return q;
  endfunction
  function automatic int pick_shift(input int mn, input int mx);
    for (int s = 0; s <= MAX_SHIFT; s++)
      if (fdiv(mx, s) <= 7 && fdiv(mn, s) >= -8) return s;
    return MAX_SHIFT;
  endfunction
  function automatic logic [3:0] nib(input logic [15:0] x, input int s);
    int q = fdiv(int'($signed(x)), s);
    q = q > 7 ? 7 : q < -8 ? -8 : q;
    return 4'(q);
  endfunction
  task automatic expect_block(input bit last, input bit loop);
    int mn = 32767, mx = -32768, s;
    for (int i = 0; i < 16; i++) begin
      int v;
      v = int'($signed(blk[i]));
      if (v < mn) mn = v;
      if (v > mx) mx = v;
    end
    s = pick_shift(mn, mx);
    expq.push_back({exp_addr, 4'(s), 2'b00, loop & last, last});
    exp_addr++;
    for (int k = 0; k < 8; k++) begin
      expq.push_back({exp_addr, nib(blk[2 * k], s), nib(blk[2 * k + 1], s)});
      exp_addr++;
    end
  endtask
  task automatic start_run(input logic [15:0] addr);
    wlog.delete();
    expq.delete();
    done_cnt = 0;
    exp_addr = addr;
    @(negedge clock);
    start = 1;
    start_address = addr;
    @(negedge clock);
    start = 0;
    @(negedge clock);
    start = 1;
    start_address = 16'($urandom);
    @(negedge clock);
    start = 0;
  endtask
  task automatic feed_block(input int n, input bit last, input bit loop, input int gap_pct);
    int i = 0, guard = 0;
    while (i < n && guard < 3000) begin
      @(negedge clock);
      guard++;
      bus.sample_valid = $urandom_range(99) >= gap_pct;
      bus.sample_in = blk[i];
      bus.last_block = i == 15 ? last : 1'($urandom);
      bus.loop_flag = i == 15 ? loop : 1'($urandom);
      if (bus.sample_valid && bus.sample_ready) i++;
    end
    if (i < n) check("feed_timeout", 0, 1);
    @(negedge clock);
    bus.sample_valid = 0;
  endtask
  task automatic finish_run(input string tag);
    int t = 0;
    while (busy && t < 5000) begin
      @(negedge clock);
      t++;
    end
    check({tag, "_timeout"}, busy, 0);
    @(negedge clock);
    check({tag, "_wr_count"}, wlog.size(), expq.size());
    for (int i = 0; i < wlog.size() && i < expq.size(); i++) check({tag, "_write"}, wlog[i], expq[i]);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_ready_idle"}, bus.sample_ready, 0);
  endtask
  task automatic check_quiet(input string tag);
    check({tag, "_req"}, bus.ram_write_request, 0);
    check({tag, "_ready"}, bus.sample_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_addr"}, bus.ram_address, 0);
    check({tag, "_data"}, bus.ram_data_out, 0);
  endtask
  task automatic rand_block();
    int amp;
    case ($urandom_range(3))
      0: amp = 8;
      1: amp = 128;
      2: amp = 4096;
      default: amp = 32768;
    endcase
    for (int i = 0; i < 16; i++) blk[i] = 16'($urandom_range(2 * amp - 1) - amp);
  endtask
  initial begin
    tv[0] = '{16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 8'h01, 8'h00, 8'h00};
    tv[1] = '{16'h0200, 16'h0007, 16'hFFF8, 16'h0007, 16'hFFF8, 0, 0, 8'h00, 8'h78, 8'h78};
    tv[2] = '{16'h1000, 16'h0070, 16'h0070, 16'h0070, 16'h0070, 1, 1, 8'h43, 8'h77, 8'h77};
    tv[3] = '{16'h0300, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 1, 0, 8'hC1, 8'h78, 8'h00};
    tv[4] = '{16'h0400, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 8'h00, 8'h00, 8'h00};
    tv[5] = '{16'h0500, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 1, 8'h03, 8'hFF, 8'hFF};
    tv[6] = '{16'h0600, 16'h0008, 16'h0008, 16'h0008, 16'h0008, 1, 0, 8'h11, 8'h44, 8'h44};
    tv[7] = '{16'h0700, 16'hFFF7, 16'hFFF7, 16'hFFF7, 16'hFFF7, 1, 0, 8'h11, 8'hBB, 8'hBB};
    tv[8] = '{16'hFFFC, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 8'h01, 8'h00, 8'h00};
    tv[9] = '{16'h0800, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1, 0, 8'hC1, 8'h77, 8'h77};
    reset = 1;
    start = 0;
    start_address = 0;
    bus.sample_in = 0;
    bus.sample_valid = 0;
    bus.last_block = 0;
    bus.loop_flag = 0;
    repeat (3) @(negedge clock);
    check_quiet("reset");
    reset = 0;
    @(negedge clock);
    check_quiet("idle");
    // table vectors; a non-final block is followed by a zero end block at the next address
    for (int v = 0; v < 10; v++) begin
      start_run(tv[v].addr);
      for (int i = 0; i < 16; i++) blk[i] = i == 0 ? tv[v].s0 : i == 1 ? tv[v].s1 : i[0] ? tv[v].od : tv[v].ev;
      expq.push_back({exp_addr, tv[v].hdr});
      exp_addr++;
      for (int k = 0; k < 8; k++) begin
        expq.push_back({exp_addr, k == 0 ? tv[v].b0 : tv[v].bn});
        exp_addr++;
      end
      feed_block(16, tv[v].last, tv[v].loop, 0);
      if (!tv[v].last) begin
        for (int i = 0; i < 16; i++) blk[i] = 0;
        for (int k = 0; k < 9; k++) begin
          expq.push_back({exp_addr, k == 0 ? 8'h01 : 8'h00});
          exp_addr++;
        end
        feed_block(16, 1, 0, 0);
      end
      finish_run($sformatf("vec%0d", v));
    end
    // slow RAM: every byte waits three cycles for its ack
    ack_delay = 3;
    start_run(16'h2000);
    rand_block();
    expect_block(1, 1);
    feed_block(16, 1, 1, 20);
    finish_run("slow_ack");
    // reset while data byte 3 is waiting for its ack
    ack_delay = 4;
    start_run(16'h0300);
    for (int i = 0; i < 16; i++) blk[i] = i[0] ? 16'hFFF8 : 16'h0007;
    expect_block(1, 0);
    feed_block(16, 1, 0, 0);
    for (int t = 0; t < 200 && wlog.size() < 4; t++) @(negedge clock);
    check("rst_wait_req", bus.ram_write_request, 1);
    check("rst_wait_addr", bus.ram_address, 16'h0304);
    reset = 1;
    @(negedge clock);
    check_quiet("rst_mid");
    reset = 0;
    repeat (5) begin
      @(negedge clock);
      check("rst_ready_low", bus.sample_ready, 0);
    end
    check("rst_wr_count", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) check("rst_write", wlog[i], expq[i]);
    // reset part-way through collection, then a fresh block must start from sample 0
    ack_delay = 0;
    start_run(16'h0900);
    rand_block();
    feed_block(5, 0, 0, 0);
    reset = 1;
    @(negedge clock);
    check_quiet("rst_collect");
    reset = 0;
    start_run(16'h0A00);
    rand_block();
    expect_block(1, 0);
    feed_block(16, 1, 0, 10);
    finish_run("after_rst");
    // randomized multi-block runs against the model
    for (int r = 0; r < 15; r++) begin
      int nb;
      nb = $urandom_range(1, 3);
      ack_delay = $urandom_range(2);
      start_run(16'($urandom));
      for (int b = 0; b < nb; b++) begin
        bit lp;
        lp = 1'($urandom);
        rand_block();
        expect_block(b == nb - 1, lp);
        feed_block(16, b == nb - 1, lp, 30);
      end
      finish_run($sformatf("rand%0d", r));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/brr_encoder.md
BRR_ENCODER -- requirements
Module: brr_encoder

Interface
REQ-001 SHALL have parameter MAX_SHIFT, default 12; the largest header shift value the encoder may select.
REQ-002 SHALL have input clock, 1 bit; all logic is on its rising edge.
REQ-003 SHALL have input reset, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have input start, 1 bit; a one-cycle pulse that begins an encode run.
REQ-005 SHALL have input start_address, 16 bits; the RAM address of the first block header.
REQ-006 SHALL have input sample_in, 16 bits; a signed PCM sample.
REQ-007 SHALL have input sample_valid, 1 bit; sample_in is valid this cycle.
REQ-008 SHALL have output sample_ready, 1 bit; the encoder accepts sample_in this cycle.
REQ-009 SHALL have input last_block, 1 bit; sampled together with the 16th sample of a block.
REQ-010 SHALL have input loop_flag, 1 bit; sampled together with the 16th sample of a block.
REQ-011 SHALL have output ram_address, 16 bits; the write address.
REQ-012 SHALL have output ram_data_out, 8 bits; the write data.
REQ-013 SHALL have output ram_write_request, 1 bit; a write is pending.
REQ-014 SHALL have input ram_write_ack, 1 bit; the RAM has accepted the pending write.
REQ-015 SHALL have output busy, 1 bit; asserted whenever state is not IDLE.
REQ-016 SHALL have output done, 1 bit; a one-cycle pulse when a run completes.

Function
REQ-017 SHALL implement states IDLE, COLLECT, SHIFT, WRITE_HEADER, WRITE_DATA.
REQ-018 SHALL, in IDLE, load the write pointer from start_address on start and go to COLLECT; start SHALL be ignored in all other states.
REQ-019 SHALL drive sample_ready=1 only in COLLECT.
REQ-020 SHALL store a sample on each cycle with sample_valid && sample_ready, at buffer index 0..15, and update the running signed minimum and maximum.
REQ-021 SHALL capture last_block and loop_flag when the 16th sample is accepted, then go to SHIFT.
REQ-022 SHALL, in SHIFT, select in one cycle the smallest s in 0..MAX_SHIFT with (max>>>s) <= 7 and (min>>>s) >= -8, using arithmetic shifts; if no such s exists, s SHALL be MAX_SHIFT.
REQ-023 SHALL form each nibble as (sample>>>s), clamped to the range -8..7, keeping 4 bits in two's complement; with MAX_SHIFT=12 the clamp is never active.
REQ-024 SHALL form the header byte as {s[3:0], 2'b00 (filter 0), loop bit, end bit}.
REQ-025 SHALL set the end bit to the captured last_block.
REQ-026 SHALL set the loop bit to the captured loop_flag when last_block=1, and to 0 otherwise.
REQ-027 SHALL form data byte k (k=0..7) as {nibble[2k], nibble[2k+1]}, with the earlier sample in bits [7:4].
REQ-028 SHALL write the header in WRITE_HEADER, then data bytes 0..7 in WRITE_DATA, to consecutive addresses: 9 bytes per block.
REQ-029 SHALL raise ram_write_request with ram_address and ram_data_out, and hold all three stable until the cycle in which ram_write_ack=1.
REQ-030 SHALL, in the cycle after an ack, either present the next byte or drop ram_write_request; this gives at most one write per cycle.
REQ-031 SHALL ignore ram_write_ack while ram_write_request=0.
REQ-032 SHALL, after data byte 7 is acked, go to COLLECT with the pointer at the next address if end=0.
REQ-033 SHALL, after data byte 7 is acked, pulse done for one cycle and go to IDLE if end=1.
REQ-034 SHALL let the write pointer wrap from 0xFFFF to 0x0000.

Reset
REQ-035 SHALL, on reset, go to IDLE and clear the sample count, write pointer, and min/max.
REQ-036 SHALL, on reset, drive ram_write_request=0, sample_ready=0, busy=0, done=0, ram_address=0, and ram_data_out=0, from the next cycle.
REQ-037 SHALL, on reset during a run, abandon the partial block; bytes already written are not rewritten.

Verification
REQ-038 SHALL pass this scenario: start_address=0x0200, 16 zero samples, last_block=1, loop_flag=0, immediate ack -> bytes written 0x0200=0x01, 0x0201..0x0208=0x00, done pulses once, busy=0 afterwards.
REQ-039 SHALL pass this scenario: samples alternating 7, -8, last_block=0 -> header 0x00, data bytes 0x78 x8, returns to COLLECT at pointer 0x0209.
REQ-040 SHALL pass this scenario: all samples 0x0070, last_block=1, loop_flag=1 -> header 0x43, data bytes 0x77.
REQ-041 SHALL pass this scenario: sample0=0x7FFF, sample1=0x8000, rest 0, last_block=1 -> s=12, header 0xC1, byte0=0x78, others 0x00.
REQ-042 SHALL pass this scenario: ack delayed 3 cycles per byte -> address and data held constant while waiting; 9 writes total, no duplicates.
REQ-043 SHALL pass this scenario: reset asserted during WRITE_DATA byte 3 -> ram_write_request=0 the next cycle, state IDLE, sample_ready=0 until start.
